// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - OAM DMA engine sharing the single test-memory port with the SM83 core
//
// Purpose:
//   Sits between the CPU bus and the memory model. A CPU write to DMA_REG_ADDR
//   starts (or restarts) a copy of DMA_LEN bytes from {src_hi,8'h00} to DST_BASE,
//   one byte every BYTE_CYCLES clocks. While the copy runs, only HRAM and the DMA
//   register remain reachable by the CPU.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   cpu_rd, cpu_wen               CPU read / write strobes
//   cpu_addr, cpu_w_data          CPU address / write data
//   cpu_r_data                    CPU read data (combinational)
//   cpu_stall                     CPU must hold its access this cycle
//   mem_r_addr, mem_r_data        memory read address / combinational read data
//   mem_w_addr, mem_w_data        memory write address / data
//   mem_wen                       memory write enable
//   dma_busy                      transfer in progress
//   dma_src_hi                    DMA source register contents
//
// Build option:
//   OAM_DMA_BUS_CONFLICT_EN  defined: blocked CPU reads return 8'hFF and blocked
//                            writes are dropped, no stall.
//                            undefined: blocked accesses stall until the transfer ends.

module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] DST_BASE     = 16'hFE00,
    parameter int          DMA_LEN      = 160,
    parameter int          BYTE_CYCLES  = 4,
    parameter logic [15:0] HRAM_LO      = 16'hFF80,
    parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd,
    input  logic        cpu_wen,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_w_data,
    output logic [7:0]  cpu_r_data,
    output logic        cpu_stall,
    output logic [15:0] mem_r_addr,
    output logic [15:0] mem_w_addr,
    output logic [7:0]  mem_w_data,
    output logic        mem_wen,
    input  logic [7:0]  mem_r_data,
    output logic        dma_busy,
    output logic [7:0]  dma_src_hi
);

    localparam int              SUB_W    = $clog2(BYTE_CYCLES);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BYTE_CYCLES - 1);
    localparam logic [7:0]       IDX_LAST = 8'(DMA_LEN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       src_hi_q, src_hi_d;
    logic [7:0]       idx_q, idx_d;
    logic [SUB_W-1:0] sub_q, sub_d;

    logic reg_hit;
    logic reg_wr;
    logic hram_hit;
    logic permitted;
    logic slot;
    logic cpu_access;

    assign reg_hit    = (cpu_addr == DMA_REG_ADDR);
    assign reg_wr     = cpu_wen && reg_hit;
    assign hram_hit   = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
    assign permitted  = hram_hit || reg_hit;
    assign cpu_access = cpu_rd || cpu_wen;
    // The last sub-cycle of each byte period owns the memory port.
    assign slot       = (state_q == ST_XFER) && (sub_q == SUB_LAST);

    assign dma_busy   = (state_q == ST_XFER);
    assign dma_src_hi = src_hi_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            src_hi_q <= 8'hFF;
            idx_q    <= 8'h00;
            sub_q    <= '0;
        end else begin
            state_q  <= state_d;
            src_hi_q <= src_hi_d;
            idx_q    <= idx_d;
            sub_q    <= sub_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        idx_d    = idx_q;
        sub_d    = sub_q;
        // A register write always (re)starts the copy, even on the final slot,
        // so it takes priority over the end-of-transfer return to idle.
        if (reg_wr) begin
            state_d  = ST_XFER;
            src_hi_d = cpu_w_data;
            idx_d    = 8'h00;
            sub_d    = '0;
        end else if (state_q == ST_XFER) begin
            if (slot) begin
                sub_d = '0;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = 8'h00;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        mem_r_addr = cpu_addr;
        mem_w_addr = cpu_addr;
        mem_w_data = cpu_w_data;
        mem_wen    = cpu_wen && !reg_hit;
        cpu_r_data = reg_hit ? src_hi_q : mem_r_data;
        cpu_stall  = 1'b0;

        if (state_q == ST_XFER) begin
            if (!permitted) begin
`ifdef OAM_DMA_BUS_CONFLICT_EN
                cpu_r_data = 8'hFF;
`else
                cpu_stall  = cpu_access;
`endif
                mem_wen = 1'b0;
            end
            if (slot) begin
                // Source index wraps inside the low byte; src_hi is not masked.
                mem_r_addr = {src_hi_q, idx_q};
                mem_w_addr = DST_BASE + {8'h00, idx_q};
                mem_w_data = mem_r_data;
                mem_wen    = 1'b1;
                // The following cycle is never a slot (BYTE_CYCLES >= 2), so a
                // permitted access held here completes one cycle later.
                if (permitted) begin
                    cpu_stall = cpu_access;
                end
            end
        end

        if (rst) begin
            mem_wen   = 1'b0;
            cpu_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - scoreboard bench for oam_dma_arbiter
`timescale 1ns/1ps
module tb_oam_dma_arbiter;

    localparam int LEN      = 160;
    localparam int BC       = 4;
    localparam int BUSY_CYC = LEN * BC;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wen;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_w_data, cpu_r_data;
    logic        cpu_stall;
    logic [15:0] mem_r_addr, mem_w_addr;
    logic [7:0]  mem_w_data, mem_r_data;
    logic        mem_wen;
    logic        dma_busy;
    logic [7:0]  dma_src_hi;

    oam_dma_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_rd     (cpu_rd),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_w_data (cpu_w_data),
        .cpu_r_data (cpu_r_data),
        .cpu_stall  (cpu_stall),
        .mem_r_addr (mem_r_addr),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_wen    (mem_wen),
        .mem_r_data (mem_r_data),
        .dma_busy   (dma_busy),
        .dma_src_hi (dma_src_hi)
    );

    always #5 clk = ~clk;

    // Memory model driven by the DUT
    logic [7:0] mem [0:65535];
    assign mem_r_data = mem[mem_r_addr];
    always @(posedge clk) if (mem_wen) mem[mem_w_addr] <= mem_w_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Reference model: memory image, register, and transfer schedule
    logic [7:0] ref_mem [0:65535];
    logic [7:0] m_src    = 8'hFF;
    bit         m_active = 1'b0;
    int         m_start  = 0;

    function automatic bit m_busy(int c);
        return m_active && (c >= m_start) && (c < m_start + BUSY_CYC);
    endfunction

    function automatic bit m_slot(int c);
        return m_busy(c) && (((c - m_start) % BC) == BC - 1);
    endfunction

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [31:0] c;
    } wr_t;

    logic [7:0] rd_q [$];
    wr_t        wr_q [$];

    // Monitor: pops expectations whenever the DUT presents a result
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        wr_t        w;
        if (!rst) begin
            check("dma_busy", {31'd0, dma_busy}, {31'd0, m_busy(cyc)});
            if (cpu_rd && !cpu_stall) begin
                check("read_expected", {31'd0, rd_q.size() > 0}, 32'd1);
                if (rd_q.size() > 0) begin
                    e = rd_q.pop_front();
                    check("cpu_r_data", {24'd0, cpu_r_data}, {24'd0, e});
                end
            end
            if (m_busy(cyc) && mem_wen && mem_w_addr >= 16'hFE00 && mem_w_addr < 16'hFEA0) begin
                check("oam_write_expected", {31'd0, wr_q.size() > 0}, 32'd1);
                if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    check("oam_w_addr", {16'd0, mem_w_addr}, {16'd0, w.addr});
                    check("oam_w_data", {24'd0, mem_w_data}, {24'd0, w.data});
                    check("oam_w_cycle", cyc, w.c);
                    ref_mem[w.addr] = w.data;
                end
            end
            if (cpu_wen && cpu_addr == 16'hFF46)
                check("reg_write_leak", {31'd0, mem_wen && mem_w_addr == 16'hFF46}, 32'd0);
        end
    end

    // One CPU access; called at posedge+1, returns at posedge+1.
    task automatic cpu_op(bit rd, bit wr, logic [15:0] a, logic [7:0] d);
        int  c0, exp_c, n;
        bit  hram, regh, perm, drop;
        wr_t w;
        c0   = cyc;
        hram = (a >= 16'hFF80) && (a <= 16'hFFFE);
        regh = (a == 16'hFF46);
        perm = hram || regh;
        drop = 1'b0;
        if (!m_busy(c0)) exp_c = c0;
        else if (perm) exp_c = m_slot(c0) ? c0 + 1 : c0;
        else begin
`ifdef OAM_DMA_BUS_CONFLICT_EN
            exp_c = c0;
            drop  = 1'b1;
`else
            exp_c = m_start + BUSY_CYC;
`endif
        end
        if (rd) rd_q.push_back(regh ? m_src : (drop ? 8'hFF : ref_mem[a]));
        cpu_rd = rd; cpu_wen = wr; cpu_addr = a; cpu_w_data = d;
        n = 0;
        @(negedge clk);
        while (cpu_stall && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("completion_cycle", cyc, exp_c);
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wen = 1'b0;
        if (wr) begin
            if (regh) begin
                m_src    = d;
                m_active = 1'b1;
                m_start  = cyc;
                wr_q.delete();
                for (int i = 0; i < LEN; i++) begin
                    w.addr = 16'hFE00 + 16'(i);
                    w.data = ref_mem[{d, 8'(i)}];
                    w.c    = 32'(m_start + BC * i + BC - 1);
                    wr_q.push_back(w);
                end
            end else if (!drop) begin
                ref_mem[a] = d;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy(cyc) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("dma_writes_done", wr_q.size(), 32'd0);
    endtask

    task automatic skip(int k);
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        m_active = 1'b0;
        m_src = 8'hFF;
        wr_q.delete();
        cpu_wen = 1'b1; cpu_addr = 16'h0100; cpu_w_data = 8'h99;
        #1;
        check("rst_busy_async", {31'd0, dma_busy}, 32'd0);
        check("rst_src_hi", {24'd0, dma_src_hi}, 32'hFF);
        check("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        skip(2);
        cpu_wen = 1'b0;
        rst = 1'b0;
    endtask

    task automatic read_oam();
        for (int i = 0; i <= LEN; i++) cpu_op(1'b1, 1'b0, 16'hFE00 + 16'(i), 8'h00);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] ha;
        int          r;
        rst = 1'b1; cpu_rd = 1'b0; cpu_wen = 1'b0; cpu_addr = 16'h0000; cpu_w_data = 8'h00;
        skip(3);
        check("reset_busy", {31'd0, dma_busy}, 32'd0);
        check("reset_src_hi", {24'd0, dma_src_hi}, 32'hFF);
        check("reset_stall", {31'd0, cpu_stall}, 32'd0);
        rst = 1'b0;
        skip(1);

        // Test 1: register read and plain memory access
        cpu_op(1'b1, 1'b0, 16'hFF46, 8'h00);
        cpu_op(1'b0, 1'b1, 16'h0100, 8'h12);
        cpu_op(1'b1, 1'b0, 16'h0100, 8'h00);

        // Preload sources, pre-DMA OAM contents and HRAM/boundary bytes
        for (int i = 0; i < LEN; i++) cpu_op(1'b0, 1'b1, 16'hC000 + 16'(i), 8'(i) ^ 8'h5A);
        for (int i = 0; i < LEN; i++) cpu_op(1'b0, 1'b1, 16'hD000 + 16'(i), 8'($urandom));
        for (int i = 0; i < LEN; i++) cpu_op(1'b0, 1'b1, 16'hE000 + 16'(i), 8'($urandom));
        for (int i = 0; i <= LEN; i++) cpu_op(1'b0, 1'b1, 16'hFE00 + 16'(i), 8'($urandom));
        for (int i = 0; i < 8; i++) cpu_op(1'b0, 1'b1, 16'hFF80 + 16'(i), 8'($urandom));
        cpu_op(1'b0, 1'b1, 16'hFFFE, 8'h3C);
        cpu_op(1'b0, 1'b1, 16'hFF7F, 8'h7F);
        cpu_op(1'b0, 1'b1, 16'hFFFF, 8'hE1);

        // Test 2: full transfer with random permitted CPU traffic
        cpu_op(1'b0, 1'b1, 16'hFF46, 8'hC0);
        while (cyc < m_start + BUSY_CYC - 10) begin
            skip($urandom_range(0, 5));
            r  = $urandom_range(0, 8);
            ha = (r == 8) ? 16'hFFFE : 16'hFF80 + 16'(r);
            case ($urandom_range(0, 3))
                0:       cpu_op(1'b0, 1'b1, ha, 8'($urandom));
                1, 2:    cpu_op(1'b1, 1'b0, ha, 8'h00);
                default: cpu_op(1'b1, 1'b0, 16'hFF46, 8'h00);
            endcase
        end
        wait_idle();
        read_oam();

        // Test 3: HRAM passes, blocked addresses follow the conflict option
        cpu_op(1'b0, 1'b1, 16'hFF46, 8'hC0);
        skip(7);
        cpu_op(1'b0, 1'b1, 16'hFF80, 8'h77);
        cpu_op(1'b1, 1'b0, 16'hFF80, 8'h00);
        cpu_op(1'b1, 1'b0, 16'h0100, 8'h00);
        wait_idle();
        for (int k = 0; k < 3; k++) begin
            cpu_op(1'b0, 1'b1, 16'hFF46, 8'hC0);
            skip($urandom_range(1, 20));
            case (k)
                0:       cpu_op(1'b1, 1'b0, 16'hFF7F, 8'h00);
                1:       cpu_op(1'b1, 1'b0, 16'hFFFF, 8'h00);
                default: cpu_op(1'b0, 1'b1, 16'hC000, 8'hA5);
            endcase
            wait_idle();
        end
        cpu_op(1'b1, 1'b0, 16'hC000, 8'h00);
        cpu_op(1'b1, 1'b0, 16'hFE00, 8'h00);

        // Test 4: permitted accesses landing on slot cycles
        cpu_op(1'b0, 1'b1, 16'hFF46, 8'hC0);
        for (int k = 0; k < 4; k++) begin
            skip($urandom_range(0, 9));
            while (!m_slot(cyc)) skip(1);
            if (k[0]) cpu_op(1'b0, 1'b1, 16'hFF81, 8'(k + 8'h40));
            else      cpu_op(1'b1, 1'b0, 16'hFF80, 8'h00);
        end
        cpu_op(1'b1, 1'b0, 16'hFF81, 8'h00);
        wait_idle();

        // Test 5: restart after 40 bytes, from C0 to D0
        cpu_op(1'b0, 1'b1, 16'hFF46, 8'hC0);
        while (cyc < m_start + 40 * BC) skip(1);
        cpu_op(1'b0, 1'b1, 16'hFF46, 8'hD0);
        cpu_op(1'b1, 1'b0, 16'hFF46, 8'h00);
        wait_idle();
        read_oam();

        // Test 6: reset after byte 80
        cpu_op(1'b0, 1'b1, 16'hFF46, 8'hE0);
        while (cyc < m_start + 80 * BC) skip(1);
        pulse_reset();
        skip(2);
        cpu_op(1'b1, 1'b0, 16'hFF46, 8'h00);
        cpu_op(1'b1, 1'b0, 16'h0100, 8'h00);
        read_oam();

        check("rd_queue_drained", rd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Owns the single memory port of the test memory (combinational read, one synchronous write port) and shares it between the SM83 core and an OAM DMA engine.
- A CPU write to the DMA register copies DMA_LEN bytes from {src_hi,8'h00} to DST_BASE, one byte per BYTE_CYCLES clocks.
- Sits between the core bus and the memory model.
- Restricts CPU bus access while a transfer is in progress.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source register.
- DST_BASE, 16'hFE00, first destination address (OAM).
- DMA_LEN, 160, bytes per transfer.
- BYTE_CYCLES, 4, clocks per transferred byte; must be ≥2.
- HRAM_LO / HRAM_HI, 16'hFF80 / 16'hFFFE, CPU range still accessible during DMA.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_rd  in  1  CPU read strobe.
- cpu_wen  in  1  CPU write strobe.
- cpu_addr  in  16 (addr_t)  CPU address.
- cpu_w_data  in  8 (data_t)  CPU write data.
- cpu_r_data  out  8 (data_t)  CPU read data, combinational.
- cpu_stall  out  1  CPU must hold its access this cycle.
- mem_r_addr  out  16  memory read address.
- mem_w_addr  out  16  memory write address.
- mem_w_data  out  8  memory write data.
- mem_wen  out  1  memory write enable.
- mem_r_data  in  8  memory read data, combinational.
- dma_busy  out  1  transfer in progress.
- dma_src_hi  out  8  DMA register contents.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, dma_src_hi=8'hFF, byte index=0, sub-counter=0, dma_busy=0. While rst is high, mem_wen=0 and cpu_stall=0.
- Reset mid-transfer aborts immediately. Bytes already written stay; no further writes occur.
- State IDLE (transparent mode):
  - mem_r_addr=mem_w_addr=cpu_addr, mem_w_data=cpu_w_data.
  - mem_wen=cpu_wen, except when cpu_addr==DMA_REG_ADDR.
  - cpu_r_data=mem_r_data, or dma_src_hi when cpu_addr==DMA_REG_ADDR.
  - cpu_stall=0.
- DMA register write: cpu_wen && cpu_addr==DMA_REG_ADDR, sampled at a clock edge.
  - Loads dma_src_hi, clears index and sub-counter, state goes to XFER.
  - The memory write for this address is suppressed.
- State XFER:
  - dma_busy=1; sub-counter increments modulo BYTE_CYCLES.
  - Slot cycle (sub-counter==BYTE_CYCLES-1): mem_r_addr={dma_src_hi,index}, mem_w_addr=DST_BASE+index, mem_w_data=mem_r_data, mem_wen=1. Index increments at the edge.
  - Slot cycle with index==DMA_LEN-1: state returns to IDLE at that edge.
  - dma_busy is therefore high for exactly DMA_LEN*BYTE_CYCLES cycles. The first byte is written on busy cycle BYTE_CYCLES.
- CPU accesses during XFER:
  - HRAM range and DMA_REG_ADDR are permitted.
  - In a non-slot cycle, permitted accesses pass through as in IDLE.
  - In a slot cycle, a permitted access (cpu_rd|cpu_wen) gets cpu_stall=1 and completes the next cycle, which is guaranteed non-slot.
  - All other addresses follow the Optional Feature.
- DMA register write during XFER restarts the transfer: new src_hi, index=0, sub-counter=0. Busy stays high for a full DMA_LEN*BYTE_CYCLES from the restart edge.
- Simultaneous register write and final slot: the restart wins and the state stays XFER.
- src_hi is used unmasked. The index wraps only within the low byte of the source address.

Optional Feature:
- Macro: OAM_DMA_BUS_CONFLICT_EN.
- Defined: during XFER, CPU reads outside the permitted ranges return 8'hFF with no stall, and CPU writes outside the permitted ranges are dropped (mem_wen=0).
- Undefined: such accesses hold cpu_stall=1 until the cycle after dma_busy falls, then complete normally.

Test Plan:
1. Reset -> dma_busy=0, dma_src_hi=8'hFF, and a CPU read of 16'hFF46 returns 8'hFF. Then write 8'h12 to 16'h0100 -> a read returns 8'h12.
2. Preload C000..C09F with i^8'h5A, then write 8'hC0 to FF46 -> dma_busy high for 640 cycles. FE00 is written on busy cycle 4. FE00..FE9F equal i^8'h5A. FEA0 is unchanged.
3. Mid-DMA, CPU writes 8'h77 to FF80 then reads it -> returns 8'h77. Read of 16'h0100 returns 8'hFF with conflict EN, or stalls until busy falls and then returns 8'h12 without it. A write to C000 is dropped (EN) or deferred (no EN).
4. CPU read of FF80 coinciding with a slot cycle -> cpu_stall=1 for exactly 1 cycle, correct data the next cycle. The DMA byte is still written.
5. Restart: start at 8'hC0, after 40 bytes write 8'hD0 -> busy lasts 640 cycles from the second write, and FE00..FE9F hold the D000..D09F data.
6. Assert rst at byte 80 -> dma_busy=0 asynchronously and dma_src_hi=8'hFF. FE50..FE9F keep their pre-DMA values.
